phy_reg_read_resp: RTL and testbench

PHY_REG_READ_RESP -- requirements
Module: phy_reg_read_resp

---
 rtl/phy_reg_read_resp_pkg.sv | 10 +
 rtl/phy_reg_read_resp_rr_fwd_stage.sv | 70 +++++++
 rtl/phy_reg_read_resp.sv | 100 ++++++++++
 tb/tb_phy_reg_read_resp.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_reg_read_resp_pkg.sv
// Shared configuration for the physical register read-response path.
// Data width, tag width, table size and issue width live here so every block agrees.
package phy_reg_read_resp_pkg;

    localparam int SIZE_DATA           = 32;
    localparam int SIZE_PHYSICAL_LOG   = 6;
    localparam int SIZE_PHYSICAL_TABLE = 64;
    localparam int ISSUE_WIDTH         = 4;

endpackage

// File: rtl/phy_reg_read_resp_rr_fwd_stage.sv
// One read-pipeline stage: carries a valid bit, two source tags and their data,
// swapping in any writeback that hits either tag while the stage input is captured.
module rr_fwd_stage
    import phy_reg_read_resp_pkg::*;
#(
    parameter int NUM_WR = ISSUE_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_flush,
    input  logic                         i_valid,
    input  logic [SIZE_PHYSICAL_LOG-1:0] i_tag1,
    input  logic [SIZE_PHYSICAL_LOG-1:0] i_tag2,
    input  logic [SIZE_DATA-1:0]         i_data1,
    input  logic [SIZE_DATA-1:0]         i_data2,
    input  logic                         i_wrEn   [0:NUM_WR-1],
    input  logic [SIZE_PHYSICAL_LOG-1:0] i_wrAddr [0:NUM_WR-1],
    input  logic [SIZE_DATA-1:0]         i_wrData [0:NUM_WR-1],
    output logic                         o_valid,
    output logic [SIZE_PHYSICAL_LOG-1:0] o_tag1,
    output logic [SIZE_PHYSICAL_LOG-1:0] o_tag2,
    output logic [SIZE_DATA-1:0]         o_data1,
    output logic [SIZE_DATA-1:0]         o_data2
);

    logic                         r_valid;
    logic [SIZE_PHYSICAL_LOG-1:0] r_tag1;
    logic [SIZE_PHYSICAL_LOG-1:0] r_tag2;
    logic [SIZE_DATA-1:0]         r_data1;
    logic [SIZE_DATA-1:0]         r_data2;
    logic [SIZE_DATA-1:0]         w_data1;
    logic [SIZE_DATA-1:0]         w_data2;

    // Ascending port scan so the highest-numbered matching port has the final say.
    always_comb begin
        w_data1 = i_data1;
        w_data2 = i_data2;
        for (int p = 0; p < NUM_WR; p++) begin
            if (i_wrEn[p] && (i_wrAddr[p] == i_tag1)) begin
                w_data1 = i_wrData[p];
            end
            if (i_wrEn[p] && (i_wrAddr[p] == i_tag2)) begin
                w_data2 = i_wrData[p];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid & ~i_flush;
        end
    end

    // Payload needs no reset: consumers qualify it with the valid bit.
    always_ff @(posedge clk) begin
        r_tag1  <= i_tag1;
        r_tag2  <= i_tag2;
        r_data1 <= w_data1;
        r_data2 <= w_data2;
    end

    assign o_valid = r_valid;
    assign o_tag1  = r_tag1;
    assign o_tag2  = r_tag2;
    assign o_data1 = r_data1;
    assign o_data2 = r_data2;

endmodule

// File: rtl/phy_reg_read_resp.sv
// Physical register file read path: multi-port write array feeding an RR_DEPTH-stage
// read pipeline that keeps in-flight data current with writebacks, plus a sticky collision flag.
module phy_reg_read_resp
    import phy_reg_read_resp_pkg::*;
#(
    parameter int RR_DEPTH = 1,
    parameter int NUM_WR   = ISSUE_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         recoverFlag_i,
    input  logic                         rdValid_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] phySrc1_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] phySrc2_i,
    input  logic                         wrEn_i   [0:NUM_WR-1],
    input  logic [SIZE_PHYSICAL_LOG-1:0] wrAddr_i [0:NUM_WR-1],
    input  logic [SIZE_DATA-1:0]         wrData_i [0:NUM_WR-1],
    output logic                         rdValid_o,
    output logic [SIZE_DATA-1:0]         src1Data_o,
    output logic [SIZE_DATA-1:0]         src2Data_o,
    output logic                         wrConflict_o
);

    logic [SIZE_DATA-1:0]         r_regFile [0:SIZE_PHYSICAL_TABLE-1];
    logic                         r_wrConflict;
    logic                         w_conflict;

    logic                         w_stValid [0:RR_DEPTH];
    logic [SIZE_PHYSICAL_LOG-1:0] w_stTag1  [0:RR_DEPTH];
    logic [SIZE_PHYSICAL_LOG-1:0] w_stTag2  [0:RR_DEPTH];
    logic [SIZE_DATA-1:0]         w_stData1 [0:RR_DEPTH];
    logic [SIZE_DATA-1:0]         w_stData2 [0:RR_DEPTH];

    // Later ports overwrite earlier ones on a shared tag, matching the stage forwarding order.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_WR; p++) begin
            if (wrEn_i[p]) begin
                r_regFile[wrAddr_i[p]] <= wrData_i[p];
            end
        end
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wrEn_i[i] && wrEn_i[j] && (wrAddr_i[i] == wrAddr_i[j])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrConflict <= 1'b0;
        end else begin
            r_wrConflict <= r_wrConflict | w_conflict;
        end
    end

    assign w_stValid[0] = rdValid_i;
    assign w_stTag1[0]  = phySrc1_i;
    assign w_stTag2[0]  = phySrc2_i;
    assign w_stData1[0] = r_regFile[phySrc1_i];
    assign w_stData2[0] = r_regFile[phySrc2_i];

    // Stage 1 picks up same-cycle writes over the array; later stages refresh held data.
    genvar g;
    generate
        for (g = 0; g < RR_DEPTH; g++) begin : g_stage
            rr_fwd_stage #(
                .NUM_WR (NUM_WR)
            ) u_stage (
                .clk      (clk),
                .reset    (reset),
                .i_flush  (recoverFlag_i),
                .i_valid  (w_stValid[g]),
                .i_tag1   (w_stTag1[g]),
                .i_tag2   (w_stTag2[g]),
                .i_data1  (w_stData1[g]),
                .i_data2  (w_stData2[g]),
                .i_wrEn   (wrEn_i),
                .i_wrAddr (wrAddr_i),
                .i_wrData (wrData_i),
                .o_valid  (w_stValid[g+1]),
                .o_tag1   (w_stTag1[g+1]),
                .o_tag2   (w_stTag2[g+1]),
                .o_data1  (w_stData1[g+1]),
                .o_data2  (w_stData2[g+1])
            );
        end
    endgenerate

    assign rdValid_o    = w_stValid[RR_DEPTH];
    assign src1Data_o   = w_stValid[RR_DEPTH] ? w_stData1[RR_DEPTH] : '0;
    assign src2Data_o   = w_stValid[RR_DEPTH] ? w_stData2[RR_DEPTH] : '0;
    assign wrConflict_o = r_wrConflict;

endmodule

// File: tb/tb_phy_reg_read_resp.sv
// Drives one stimulus stream into three read-pipeline depths (1, 2, 3) and checks each
// against a reference array plus a scoreboard of in-flight requests.
module tb_phy_reg_read_resp;
    import phy_reg_read_resp_pkg::*;

    localparam int NW = ISSUE_WIDTH;
    localparam int L  = SIZE_PHYSICAL_LOG;
    localparam int D  = SIZE_DATA;

    typedef struct {
        int           depth;
        int           issue;
        logic [L-1:0] t1;
        logic [L-1:0] t2;
        logic [D-1:0] d1;
        logic [D-1:0] d2;
    } entry_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         recoverFlag = 1'b0;
    logic         rdValid = 1'b0;
    logic [L-1:0] phySrc1 = '0;
    logic [L-1:0] phySrc2 = '0;
    logic         wrEn   [0:NW-1];
    logic [L-1:0] wrAddr [0:NW-1];
    logic [D-1:0] wrData [0:NW-1];

    logic         vOut  [0:2];
    logic [D-1:0] s1Out [0:2];
    logic [D-1:0] s2Out [0:2];
    logic         cOut  [0:2];

    entry_t       sb[$];
    logic [D-1:0] model [0:SIZE_PHYSICAL_TABLE-1];
    logic         expConflict = 1'b0;
    int           cyc = 0;
    int           nChecks = 0;
    int           nPassed = 0;

    always #5 clk = ~clk;

    phy_reg_read_resp #(.RR_DEPTH(1), .NUM_WR(NW)) u_d1 (
        .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag), .rdValid_i(rdValid),
        .phySrc1_i(phySrc1), .phySrc2_i(phySrc2),
        .wrEn_i(wrEn), .wrAddr_i(wrAddr), .wrData_i(wrData),
        .rdValid_o(vOut[0]), .src1Data_o(s1Out[0]), .src2Data_o(s2Out[0]), .wrConflict_o(cOut[0])
    );

    phy_reg_read_resp #(.RR_DEPTH(2), .NUM_WR(NW)) u_d2 (
        .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag), .rdValid_i(rdValid),
        .phySrc1_i(phySrc1), .phySrc2_i(phySrc2),
        .wrEn_i(wrEn), .wrAddr_i(wrAddr), .wrData_i(wrData),
        .rdValid_o(vOut[1]), .src1Data_o(s1Out[1]), .src2Data_o(s2Out[1]), .wrConflict_o(cOut[1])
    );

    phy_reg_read_resp #(.RR_DEPTH(3), .NUM_WR(NW)) u_d3 (
        .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag), .rdValid_i(rdValid),
        .phySrc1_i(phySrc1), .phySrc2_i(phySrc2),
        .wrEn_i(wrEn), .wrAddr_i(wrAddr), .wrData_i(wrData),
        .rdValid_o(vOut[2]), .src1Data_o(s1Out[2]), .src2Data_o(s2Out[2]), .wrConflict_o(cOut[2])
    );

    task automatic checkOutput(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
        nChecks++;
        if (obs === exp) begin
            nPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearWrites();
        for (int p = 0; p < NW; p++) begin
            wrEn[p]   = 1'b0;
            wrAddr[p] = '0;
            wrData[p] = '0;
        end
    endtask

    task automatic setWrite(input int p, input logic [L-1:0] a, input logic [D-1:0] d);
        wrEn[p]   = 1'b1;
        wrAddr[p] = a;
        wrData[p] = d;
    endtask

    // Pops whichever request each depth should be presenting now; anything else must be idle.
    task automatic checkCycle();
        for (int d = 1; d <= 3; d++) begin
            int     idx;
            entry_t e;
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (idx < 0 && sb[i].depth == d && sb[i].issue + d == cyc) begin
                    idx = i;
                end
            end
            if (idx >= 0) begin
                e = sb[idx];
                sb.delete(idx);
                checkOutput($sformatf("d%0d_valid@%0d", d, cyc), {31'b0, vOut[d-1]}, 1);
                checkOutput($sformatf("d%0d_src1@%0d", d, cyc), s1Out[d-1], e.d1);
                checkOutput($sformatf("d%0d_src2@%0d", d, cyc), s2Out[d-1], e.d2);
            end else begin
                checkOutput($sformatf("d%0d_valid@%0d", d, cyc), {31'b0, vOut[d-1]}, 0);
                checkOutput($sformatf("d%0d_src1@%0d", d, cyc), s1Out[d-1], 0);
                checkOutput($sformatf("d%0d_src2@%0d", d, cyc), s2Out[d-1], 0);
            end
            checkOutput($sformatf("d%0d_conflict@%0d", d, cyc), {31'b0, cOut[d-1]}, {31'b0, expConflict});
        end
    endtask

    // One cycle: check outputs, drive inputs, advance the reference, clock, return to idle inputs.
    task automatic applyStimulus(input logic rv, input logic [L-1:0] s1, input logic [L-1:0] s2,
                                 input logic rec);
        logic   coll;
        entry_t e;
        checkCycle();
        rdValid     = rv;
        phySrc1     = s1;
        phySrc2     = s2;
        recoverFlag = rec;
        if (rec) begin
            sb.delete();
        end else if (rv) begin
            for (int d = 1; d <= 3; d++) begin
                e.depth = d;
                e.issue = cyc;
                e.t1    = s1;
                e.t2    = s2;
                e.d1    = model[s1];
                e.d2    = model[s2];
                sb.push_back(e);
            end
        end
        for (int i = 0; i < sb.size(); i++) begin
            e = sb[i];
            if (cyc < e.issue + e.depth) begin
                for (int p = 0; p < NW; p++) begin
                    if (wrEn[p] && wrAddr[p] == e.t1) e.d1 = wrData[p];
                    if (wrEn[p] && wrAddr[p] == e.t2) e.d2 = wrData[p];
                end
                sb[i] = e;
            end
        end
        coll = 1'b0;
        for (int i = 0; i < NW; i++) begin
            for (int j = i + 1; j < NW; j++) begin
                if (wrEn[i] && wrEn[j] && wrAddr[i] == wrAddr[j]) coll = 1'b1;
            end
        end
        for (int p = 0; p < NW; p++) begin
            if (wrEn[p]) model[wrAddr[p]] = wrData[p];
        end
        @(posedge clk);
        #1;
        cyc++;
        if (coll) expConflict = 1'b1;
        rdValid     = 1'b0;
        recoverFlag = 1'b0;
        clearWrites();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, '0, 1'b0);
    endtask

    task automatic doReset();
        reset = 1'b0;
        #1;
        for (int d = 1; d <= 3; d++) begin
            checkOutput($sformatf("rst_d%0d_valid", d), {31'b0, vOut[d-1]}, 0);
            checkOutput($sformatf("rst_d%0d_src1", d), s1Out[d-1], 0);
            checkOutput($sformatf("rst_d%0d_src2", d), s2Out[d-1], 0);
            checkOutput($sformatf("rst_d%0d_conflict", d), {31'b0, cOut[d-1]}, 0);
        end
        sb.delete();
        expConflict = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc += 3;
    endtask

    initial begin
        clearWrites();
        #2;
        for (int d = 1; d <= 3; d++) begin
            checkOutput($sformatf("init_d%0d_valid", d), {31'b0, vOut[d-1]}, 0);
            checkOutput($sformatf("init_d%0d_src1", d), s1Out[d-1], 0);
            checkOutput($sformatf("init_d%0d_conflict", d), {31'b0, cOut[d-1]}, 0);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Seed the tags used below.
        setWrite(0, 6'd5, 32'hA5);
        setWrite(1, 6'd9, 32'h11);
        setWrite(2, 6'd3, 32'h33);
        applyStimulus(1'b0, '0, '0, 1'b0);
        setWrite(3, 6'd12, 32'hC0DE);
        setWrite(1, 6'd7, 32'h70);
        applyStimulus(1'b0, '0, '0, 1'b0);

        applyStimulus(1'b1, 6'd5, 6'd5, 1'b0);
        idle(4);

        applyStimulus(1'b1, 6'd9, 6'd9, 1'b0);
        idle(1);
        setWrite(2, 6'd9, 32'h22);
        applyStimulus(1'b0, '0, '0, 1'b0);
        setWrite(0, 6'd9, 32'h33);
        applyStimulus(1'b0, '0, '0, 1'b0);
        idle(3);

        setWrite(1, 6'd3, 32'h3030);
        applyStimulus(1'b1, 6'd3, 6'd12, 1'b0);
        idle(4);

        for (int k = 0; k < 24; k++) begin
            logic [L-1:0] tags [0:3];
            tags[0] = 6'd3; tags[1] = 6'd5; tags[2] = 6'd9; tags[3] = 6'd12;
            if ($urandom_range(0, 1) == 1) begin
                setWrite($urandom_range(0, NW - 1), tags[$urandom_range(0, 3)], $urandom);
            end
            applyStimulus($urandom_range(0, 2) != 0, tags[$urandom_range(0, 3)],
                          tags[$urandom_range(0, 3)], 1'b0);
        end
        idle(4);

        applyStimulus(1'b1, 6'd5, 6'd9, 1'b0);
        setWrite(0, 6'd12, 32'hBEEF);
        applyStimulus(1'b1, 6'd3, 6'd12, 1'b1);
        idle(3);
        applyStimulus(1'b1, 6'd12, 6'd12, 1'b0);
        idle(4);

        setWrite(0, 6'd7, 32'h1);
        setWrite(1, 6'd7, 32'h2);
        applyStimulus(1'b1, 6'd7, 6'd7, 1'b0);
        idle(4);

        applyStimulus(1'b1, 6'd5, 6'd7, 1'b0);
        applyStimulus(1'b1, 6'd9, 6'd3, 1'b0);
        doReset();
        idle(4);
        applyStimulus(1'b1, 6'd7, 6'd12, 1'b0);
        idle(4);

        $display("[TB] %0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
